appr_mac_accumulator: RTL and testbench
=======================================

Name: appr_mac_accumulator

Overview:
- Downstream stage of the registered 9x9 reconfigurable approximate multiplier.
- Consumes its signed 18-bit products through a valid/ready handshake.
- Accumulates a programmable number of products per window into a wide signed accumulator.
- Presents each window's dot-product result with a valid/ready handshake to the next stage (requantiser / writeback).

Parameters:
- PROD_WIDTH, 18, signed product width; equals the multiplier output width.
- ACC_WIDTH, 32, signed accumulator and result width; must be >= PROD_WIDTH.
- LEN_WIDTH, 8, width of the window-length configuration.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous abort of the current window; priority below rst.
- cfg_len  in  LEN_WIDTH  products per window; sampled on the first accepted product of a window; 0 is treated as 1.
- in_valid  in  1  product valid.
- in_ready  out  1  block can accept a product.
- in_prod  in  PROD_WIDTH  signed product, two's complement.
- out_valid  out  1  window result valid.
- out_ready  in  1  consumer accepts the result.
- out_acc  out  ACC_WIDTH  signed window sum.
- out_sat  out  1  saturation occurred in this window; tied to 0 when the optional feature is disabled.
- busy  out  1  high in ACC or DONE.

Behaviour:
- Reset: state=IDLE, acc=0, cnt=0, len_q=1, out_valid=0, out_acc=0, out_sat=0, busy=0, in_ready=1 in the cycle after rst is sampled high.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready at the clock edge.
  - Output transfer occurs when out_valid && out_ready.
  - in_valid/in_prod need not be held by the producer; once asserted, out_valid/out_acc/out_sat stay stable until the output transfer.
- FSM has three states: IDLE, ACC, DONE.
  - in_ready = (state != DONE); it depends on state only, with no combinational path from out_ready.
  - IDLE, on input transfer:
    - acc <= sign-extended in_prod; cnt <= 1; len_q <= max(cfg_len, 1); out_sat cleared.
    - Next state is DONE if the effective length is 1, else ACC.
  - ACC, on input transfer:
    - acc <= acc + sign-extended in_prod; cnt <= cnt + 1.
    - If cnt + 1 == len_q, go to DONE; otherwise stay in ACC.
    - With no transfer, all state holds.
  - DONE: out_valid=1 and out_acc=acc. On output transfer go to IDLE, with out_valid=0 the next cycle.
- Latency: out_valid rises in the cycle after the last product of a window is accepted.
- Throughput: a window of L products occupies L accepting cycles plus at least 1 DONE cycle, which is a bubble even when out_ready is held high.
- Arithmetic:
  - Full two's-complement add at ACC_WIDTH.
  - Without the optional feature, overflow wraps modulo 2^ACC_WIDTH.
  - cnt is LEN_WIDTH+1 bits wide and never wraps, because len_q <= 2^LEN_WIDTH-1.
- cfg_len changes mid-window have no effect; only the value sampled at window start is used.
- clr:
  - From any state, next state is IDLE, acc=0, cnt=0, out_valid=0, out_sat=0.
  - Any input transfer in the same cycle is dropped.
  - A pending result in DONE is discarded.
  - rst has priority over clr.
- Mid-window rst: behaves exactly as the reset state; partial sums are lost and no output is produced.
- busy = (state != IDLE).

Optional Feature:
- Macro: APPR_ACC_SAT_EN.
- Defined:
  - Each addition saturates to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) on signed overflow. Overflow is detected when both operands have the same sign and the result sign differs.
  - out_sat is set sticky for the remainder of the window and cleared at the next window start, clr, or rst.
  - Later additions continue from the clamped value.
- Undefined: the adder wraps and out_sat is constant 0.

Test Plan:
- Window of 4:
  - Stimulus: rst 2 cycles, cfg_len=4, back-to-back products 100, -30, 65280, -65536 with out_ready=1.
  - Required: out_valid exactly one cycle after the 4th transfer, out_acc=-186, in_ready=0 for that cycle, then IDLE.
- cfg_len=0 and 1:
  - Stimulus: single product -5.
  - Required: out_acc=-5 one cycle later, for both values.
- Backpressure:
  - Stimulus: cfg_len=2, products 7 and 9, out_ready=0 for 5 cycles.
  - Required: out_valid=1 and out_acc=16 held stable, in_ready=0 throughout, in_valid ignored; transfer on out_ready=1, next window accepted the following cycle.
- clr / rst mid-window:
  - Stimulus: cfg_len=3, 2 products accepted, then clr with in_valid=1, then a fresh 3-product window 1, 2, 3.
  - Required: out_acc=6 and no earlier output. Repeat with rst instead of clr for the same result.
- cfg_len change mid-window:
  - Stimulus: window started with cfg_len=3, cfg_len changed to 1 after the first product.
  - Required: result after 3 products.
- Overflow (ACC_WIDTH=20):
  - Stimulus: 5 products of +131071.
  - Required without APPR_ACC_SAT_EN: out_acc wraps to 655355-1048576=-393221, out_sat=0.
  - Required with APPR_ACC_SAT_EN: out_acc=524287, out_sat=1; out_sat=0 in the next window.

Source files
------------

// File: rtl/appr_mac_accumulator.sv
// Windowed signed accumulator behind the approximate multiplier: sums cfg_len products
// per window and hands each sum downstream. Optional saturation: APPR_ACC_SAT_EN.
module appr_mac_accumulator #(
   parameter int PROD_WIDTH = 18,
   parameter int ACC_WIDTH  = 32,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic [LEN_WIDTH-1:0]  cfg_len,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [PROD_WIDTH-1:0] in_prod,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  out_acc,
   output logic                  out_sat,
   output logic                  busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                        r_state;
   state_t                        w_state_next;
   logic signed [ACC_WIDTH-1:0]   r_acc;
   logic        [LEN_WIDTH:0]     r_cnt;
   logic        [LEN_WIDTH-1:0]   r_len_q;

   logic                          w_in_xfer;
   logic                          w_out_xfer;
   logic        [LEN_WIDTH-1:0]   w_len_eff;
   logic        [LEN_WIDTH:0]     w_cnt_inc;
   logic                          w_last;
   logic signed [ACC_WIDTH-1:0]   w_prod_ext;
   logic signed [ACC_WIDTH-1:0]   w_sum;
   logic signed [ACC_WIDTH-1:0]   w_acc_next;

   assign in_ready   = (r_state != S_DONE);
   assign out_valid  = (r_state == S_DONE);
   assign busy       = (r_state != S_IDLE);
   assign out_acc    = r_acc;

   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = out_valid && out_ready;

   // A programmed length of zero behaves as a single-product window.
   assign w_len_eff  = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
   assign w_cnt_inc  = r_cnt + (LEN_WIDTH+1)'(1);
   assign w_last     = (w_cnt_inc == {1'b0, r_len_q});

   assign w_prod_ext = ACC_WIDTH'(signed'(in_prod));
   assign w_sum      = r_acc + w_prod_ext;

`ifdef APPR_ACC_SAT_EN
   logic r_sat;
   logic w_ovf;

   // Overflow only when both addends share a sign the result does not.
   assign w_ovf = (r_acc[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                  (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

   always_comb begin
      w_acc_next = w_sum;
      if (w_ovf) begin
         w_acc_next = r_acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_sat <= 1'b0;
      end else if (w_in_xfer) begin
         if (r_state == S_IDLE) begin
            r_sat <= 1'b0;
         end else if (r_state == S_ACC) begin
            r_sat <= r_sat | w_ovf;
         end
      end
   end

   assign out_sat = r_sat;
`else
   assign w_acc_next = w_sum;
   assign out_sat    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (clr) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_in_xfer) begin
                  w_state_next = (w_len_eff == LEN_WIDTH'(1)) ? S_DONE : S_ACC;
               end
            end
            S_ACC: begin
               if (w_in_xfer && w_last) begin
                  w_state_next = S_DONE;
               end
            end
            S_DONE: begin
               if (w_out_xfer) begin
                  w_state_next = S_IDLE;
               end
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   // Window datapath; clr drops any same-cycle input transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc   <= '0;
         r_cnt   <= '0;
         r_len_q <= LEN_WIDTH'(1);
      end else if (clr) begin
         r_acc   <= '0;
         r_cnt   <= '0;
      end else if (w_in_xfer) begin
         if (r_state == S_IDLE) begin
            r_acc   <= w_prod_ext;
            r_cnt   <= (LEN_WIDTH+1)'(1);
            r_len_q <= w_len_eff;
         end else if (r_state == S_ACC) begin
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_inc;
         end
      end
   end

endmodule

// File: tb/tb_appr_mac_accumulator.sv
// Directed bench for appr_mac_accumulator at ACC_WIDTH=20; expectations follow
// APPR_ACC_SAT_EN when the overflow window is checked.
module tb_appr_mac_accumulator;

   localparam int PW = 18;
   localparam int AW = 20;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          clr;
   logic [LW-1:0] cfg_len;
   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] in_prod;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_acc;
   logic          out_sat;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;

   appr_mac_accumulator #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .cfg_len   (cfg_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_prod   (in_prod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_sat   (out_sat),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s: %0d", tag, obs);
      end
   endtask

   // Outputs are observed 1 time unit after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input longint p);
      in_valid = 1'b1;
      in_prod  = PW'(p);
      tick();
      in_valid = 1'b0;
   endtask

   longint acc_s;
   longint exp_ovf;
   int     exp_sat;

   initial begin
      rst = 1'b1; clr = 1'b0; cfg_len = '0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out_acc", out_acc, 0);
      check("rst_out_sat", out_sat, 0);

      // Window of 4, back-to-back
      cfg_len = 8'd4;
      push(100); push(-30); push(65280);
      check("w4_no_early_valid", out_valid, 0);
      check("w4_busy", busy, 1);
      push(-65536);
      acc_s = longint'($signed(out_acc));
      check("w4_valid", out_valid, 1);
      check("w4_acc", acc_s, -186);
      check("w4_in_ready_low", in_ready, 0);
      tick();
      check("w4_back_idle_valid", out_valid, 0);
      check("w4_back_idle_busy", busy, 0);

      // Length 0 and 1 both behave as single-product windows
      for (int l = 0; l < 2; l++) begin
         cfg_len = LW'(l);
         push(-5);
         acc_s = longint'($signed(out_acc));
         check($sformatf("len%0d_valid", l), out_valid, 1);
         check($sformatf("len%0d_acc", l), acc_s, -5);
         tick();
         check($sformatf("len%0d_idle", l), out_valid, 0);
      end

      // Backpressure: result must hold, input ignored
      cfg_len = 8'd2; out_ready = 1'b0;
      push(7); push(9);
      in_valid = 1'b1; in_prod = PW'(1000);
      for (int c = 0; c < 5; c++) begin
         acc_s = longint'($signed(out_acc));
         check($sformatf("bp%0d_valid", c), out_valid, 1);
         check($sformatf("bp%0d_acc", c), acc_s, 16);
         check($sformatf("bp%0d_in_ready", c), in_ready, 0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("bp_released", out_valid, 0);
      cfg_len = 8'd1; in_prod = PW'(3);
      tick();
      in_valid = 1'b0;
      acc_s = longint'($signed(out_acc));
      check("bp_next_valid", out_valid, 1);
      check("bp_next_acc", acc_s, 3);
      tick();

      // Abort mid-window via clr (k=0) and via rst (k=1)
      for (int k = 0; k < 2; k++) begin
         cfg_len = 8'd3;
         push(50); push(60);
         if (k == 0) clr = 1'b1; else rst = 1'b1;
         in_valid = 1'b1; in_prod = PW'(70);
         tick();
         clr = 1'b0; rst = 1'b0; in_valid = 1'b0;
         check($sformatf("abort%0d_valid", k), out_valid, 0);
         check($sformatf("abort%0d_busy", k), busy, 0);
         push(1); push(2);
         check($sformatf("abort%0d_no_early", k), out_valid, 0);
         push(3);
         acc_s = longint'($signed(out_acc));
         check($sformatf("abort%0d_valid_after", k), out_valid, 1);
         check($sformatf("abort%0d_acc", k), acc_s, 6);
         tick();
      end

      // cfg_len change after window start has no effect
      cfg_len = 8'd3;
      push(10);
      cfg_len = 8'd1;
      push(20);
      check("cfgchg_no_early", out_valid, 0);
      push(30);
      acc_s = longint'($signed(out_acc));
      check("cfgchg_valid", out_valid, 1);
      check("cfgchg_acc", acc_s, 60);
      tick();

      // Overflow window: 5 x 131071 at 20 bits
`ifdef APPR_ACC_SAT_EN
      exp_ovf = 524287; exp_sat = 1;
`else
      exp_ovf = -393221; exp_sat = 0;
`endif
      cfg_len = 8'd5;
      for (int i = 0; i < 5; i++) push(131071);
      acc_s = longint'($signed(out_acc));
      check("ovf_valid", out_valid, 1);
      check("ovf_acc", acc_s, exp_ovf);
      check("ovf_sat", out_sat, exp_sat);
      tick();
      cfg_len = 8'd1;
      push(1);
      acc_s = longint'($signed(out_acc));
      check("ovf_next_acc", acc_s, 1);
      check("ovf_next_sat", out_sat, 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
